comled_ctl_mc: RTL and testbench

- Multi-channel communication LED controller. Drives one green (activity) and one red (error) indicator per channel.
- Activity is qualified over a configurable window of millisecond ticks. Errors are synchronised through a configurable-depth chain and stretched by a configurable hold time.
- Adds lamp test and a global error summary.
- Sits in the ledm subsystem between the per-slot communication receivers and the LED driver pins.

---
 rtl/comled_pkg.sv | 21 ++
 rtl/comled_if.sv | 24 ++
 rtl/comled_ch.sv | 111 +++++++++++
 rtl/comled_ctl_mc.sv | 75 +++++++
 tb/tb_comled_ctl_mc.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/comled_pkg.sv
// Shared types and constants for the multi-channel communication LED controller.
package comled_pkg;

    localparam int unsigned HoldW      = 10;
    localparam int unsigned MsCntW     = 8;

    localparam int unsigned NChMin     = 1;
    localparam int unsigned NChMax     = 32;
    localparam int unsigned WinMsMin   = 1;
    localparam int unsigned WinMsMax   = 255;
    localparam int unsigned SyncStgMin = 2;
    localparam int unsigned SyncStgMax = 4;
    localparam int unsigned ErrHoldMax = 1023;

    typedef enum logic [1:0] {
        RIdle = 2'd0,
        ROn   = 2'd1,
        RHold = 2'd2
    } red_st_e;

endpackage

// File: rtl/comled_if.sv
// Bundle of control inputs and LED outputs between the receivers and the LED pins.
interface comled_if #(
    parameter int unsigned N_CH = 4
);
    logic            clk_ms_en;
    logic            self_cfg_err;
    logic            lamp_test;
    logic [N_CH-1:0] slot_en;
    logic [N_CH-1:0] eop_trig;
    logic [N_CH-1:0] err_trig;
    logic [N_CH-1:0] led_grn;
    logic [N_CH-1:0] led_red;
    logic            err_any;

    modport master (
        output clk_ms_en, self_cfg_err, lamp_test, slot_en, eop_trig, err_trig,
        input  led_grn, led_red, err_any
    );

    modport slave (
        input  clk_ms_en, self_cfg_err, lamp_test, slot_en, eop_trig, err_trig,
        output led_grn, led_red, err_any
    );
endinterface

// File: rtl/comled_ch.sv
// One channel: activity counter, error synchroniser, red stretch FSM and both LED flops.
module comled_ch
    import comled_pkg::*;
#(
    parameter int unsigned ACT_MIN     = 1,
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned SYNC_STG    = 3,
    parameter int unsigned ERR_HOLD_MS = 0
) (
    input  logic clk_sys,
    input  logic rst_sys_n,
    input  logic win_end_i,
    input  logic ms_en_i,
    input  logic cfg_err_i,
    input  logic lamp_i,
    input  logic slot_en_i,
    input  logic eop_i,
    input  logic err_i,
    output logic led_grn_o,
    output logic led_red_o
);

    logic [CNT_W-1:0]    act_cnt_q, act_cnt_d;
    logic [SYNC_STG-1:0] sync_q;
    logic                err_s;
    red_st_e             st_q, st_d;
    logic [HoldW-1:0]    hold_q, hold_d;
    logic                grn_st_q, grn_st_d;
    logic                led_grn_q, led_grn_d;
    logic                led_red_q, led_red_d;

    assign err_s = sync_q[SYNC_STG-1];

    always_comb begin
        act_cnt_d = act_cnt_q;
        if (win_end_i) begin
            act_cnt_d = '0;
        end else if (eop_i && (act_cnt_q != {CNT_W{1'b1}})) begin
            act_cnt_d = act_cnt_q + CNT_W'(1);
        end

        st_d   = st_q;
        hold_d = hold_q;
        if (cfg_err_i || !slot_en_i) begin
            st_d   = RIdle;
            hold_d = '0;
        end else begin
            case (st_q)
                RIdle: if (err_s) st_d = ROn;
                ROn: begin
                    if (!err_s) begin
                        if (ERR_HOLD_MS == 0) begin
                            st_d = RIdle;
                        end else begin
                            st_d   = RHold;
                            hold_d = HoldW'(ERR_HOLD_MS);
                        end
                    end
                end
                RHold: begin
                    if (err_s) begin
                        st_d = ROn;
                    end else if (ms_en_i) begin
                        if (hold_q == HoldW'(1)) begin
                            st_d   = RIdle;
                            hold_d = '0;
                        end else begin
                            hold_d = hold_q - HoldW'(1);
                        end
                    end
                end
                default: st_d = RIdle;
            endcase
        end

        // Display state kept apart from the LED flop so lamp test cannot corrupt it.
        grn_st_d = grn_st_q;
        if (cfg_err_i || !slot_en_i || (st_q != RIdle)) begin
            grn_st_d = 1'b0;
        end else if (win_end_i) begin
            grn_st_d = (act_cnt_q >= CNT_W'(ACT_MIN)) ? !grn_st_q : 1'b0;
        end

        led_grn_d = cfg_err_i ? 1'b0 : (lamp_i ? 1'b1 : grn_st_d);
        led_red_d = cfg_err_i ? 1'b0 : (lamp_i ? 1'b1 : (st_d != RIdle));
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            act_cnt_q <= '0;
            sync_q    <= '0;
            st_q      <= RIdle;
            hold_q    <= '0;
            grn_st_q  <= 1'b0;
            led_grn_q <= 1'b0;
            led_red_q <= 1'b0;
        end else begin
            act_cnt_q <= act_cnt_d;
            sync_q    <= {sync_q[SYNC_STG-2:0], err_i};
            st_q      <= st_d;
            hold_q    <= hold_d;
            grn_st_q  <= grn_st_d;
            led_grn_q <= led_grn_d;
            led_red_q <= led_red_d;
        end
    end

    assign led_grn_o = led_grn_q;
    assign led_red_o = led_red_q;

endmodule

// File: rtl/comled_ctl_mc.sv
// Multi-channel comm LED controller: shared window timer, per-channel logic, error summary.
module comled_ctl_mc
    import comled_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned WIN_MS      = 1,
    parameter int unsigned ACT_MIN     = 1,
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned SYNC_STG    = 3,
    parameter int unsigned ERR_HOLD_MS = 0
) (
    input  logic     clk_sys,
    input  logic     rst_sys_n,
    comled_if.slave  bus
);

    localparam bit ParamsOk = (N_CH >= NChMin) && (N_CH <= NChMax) &&
                              (WIN_MS >= WinMsMin) && (WIN_MS <= WinMsMax) &&
                              (SYNC_STG >= SyncStgMin) && (SYNC_STG <= SyncStgMax) &&
                              (ERR_HOLD_MS <= ErrHoldMax);

    logic [MsCntW-1:0] ms_cnt_q, ms_cnt_d;
    logic              win_end;
    logic [N_CH-1:0]   led_grn, led_red;
    logic              err_any_q;

    always_comb begin : param_check
        assert (ParamsOk) else $error("comled_ctl_mc: parameter out of range");
    end

    assign win_end = bus.clk_ms_en && (ms_cnt_q == MsCntW'(WIN_MS - 1));

    always_comb begin
        ms_cnt_d = ms_cnt_q;
        if (bus.clk_ms_en) begin
            ms_cnt_d = win_end ? '0 : ms_cnt_q + MsCntW'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : gen_ch
        comled_ch #(
            .ACT_MIN    (ACT_MIN),
            .CNT_W      (CNT_W),
            .SYNC_STG   (SYNC_STG),
            .ERR_HOLD_MS(ERR_HOLD_MS)
        ) u_ch (
            .clk_sys  (clk_sys),
            .rst_sys_n(rst_sys_n),
            .win_end_i(win_end),
            .ms_en_i  (bus.clk_ms_en),
            .cfg_err_i(bus.self_cfg_err),
            .lamp_i   (bus.lamp_test),
            .slot_en_i(bus.slot_en[i]),
            .eop_i    (bus.eop_trig[i]),
            .err_i    (bus.err_trig[i]),
            .led_grn_o(led_grn[i]),
            .led_red_o(led_red[i])
        );
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ms_cnt_q  <= '0;
            err_any_q <= 1'b0;
        end else begin
            ms_cnt_q  <= ms_cnt_d;
            err_any_q <= |led_red;
        end
    end

    assign bus.led_grn = led_grn;
    assign bus.led_red = led_red;
    assign bus.err_any = err_any_q;

endmodule

// File: tb/tb_comled_ctl_mc.sv
// Directed bench: three controller instances (default, wide window, red stretch) share stimulus.
module tb_comled_ctl_mc;

    logic       clk_sys = 1'b0;
    logic       rst_sys_n;
    logic       ms_en, cfg, lamp;
    logic [3:0] slot, eop, err;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    comled_if #(.N_CH(4)) if_a ();
    comled_if #(.N_CH(4)) if_b ();
    comled_if #(.N_CH(4)) if_c ();

    assign if_a.clk_ms_en = ms_en;  assign if_b.clk_ms_en = ms_en;  assign if_c.clk_ms_en = ms_en;
    assign if_a.self_cfg_err = cfg; assign if_b.self_cfg_err = cfg; assign if_c.self_cfg_err = cfg;
    assign if_a.lamp_test = lamp;   assign if_b.lamp_test = lamp;   assign if_c.lamp_test = lamp;
    assign if_a.slot_en = slot;     assign if_b.slot_en = slot;     assign if_c.slot_en = slot;
    assign if_a.eop_trig = eop;     assign if_b.eop_trig = eop;     assign if_c.eop_trig = eop;
    assign if_a.err_trig = err;     assign if_b.err_trig = err;     assign if_c.err_trig = err;

    comled_ctl_mc #(.N_CH(4)) dut_a (.clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .bus(if_a));
    comled_ctl_mc #(.N_CH(4), .WIN_MS(4), .ACT_MIN(3)) dut_b (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .bus(if_b)
    );
    comled_ctl_mc #(.N_CH(4), .ERR_HOLD_MS(3)) dut_c (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .bus(if_c)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic tick();
        ms_en = 1'b1; step(1); ms_en = 1'b0;
    endtask

    task automatic eops(input int ch, input int n);
        eop[ch] = 1'b1; step(n); eop[ch] = 1'b0;
    endtask

    task automatic do_reset();
        ms_en = 0; cfg = 0; lamp = 0; slot = 4'hF; eop = 0; err = 0;
        rst_sys_n = 1'b0; step(2); rst_sys_n = 1'b1; step(1);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if ({if_a.led_grn, if_a.led_red, if_a.err_any} !== 9'h0) begin
            n_bad++; $display("FAIL reset_a: got %h want 000", {if_a.led_grn, if_a.led_red, if_a.err_any});
        end
        n_cmp++; if ({if_b.led_grn, if_b.led_red, if_b.err_any} !== 9'h0) begin
            n_bad++; $display("FAIL reset_b: got %h want 000", {if_b.led_grn, if_b.led_red, if_b.err_any});
        end
        n_cmp++; if ({if_c.led_grn, if_c.led_red, if_c.err_any} !== 9'h0) begin
            n_bad++; $display("FAIL reset_c: got %h want 000", {if_c.led_grn, if_c.led_red, if_c.err_any});
        end
    endtask

    task automatic test_activity();
        do_reset();
        eops(0, 3); tick();
        n_cmp++; if (if_a.led_grn !== 4'b0001) begin
            n_bad++; $display("FAIL act_toggle_on: got %b want 0001", if_a.led_grn);
        end
        eops(0, 3); tick();
        n_cmp++; if (if_a.led_grn !== 4'b0000) begin
            n_bad++; $display("FAIL act_toggle_off: got %b want 0000", if_a.led_grn);
        end
        eops(0, 3); tick();
        n_cmp++; if (if_a.led_grn !== 4'b0001) begin
            n_bad++; $display("FAIL act_toggle_on2: got %b want 0001", if_a.led_grn);
        end
        tick();
        n_cmp++; if (if_a.led_grn !== 4'b0000) begin
            n_bad++; $display("FAIL act_idle_window: got %b want 0000", if_a.led_grn);
        end
    endtask

    task automatic test_window();
        do_reset();
        eops(0, 2); repeat (4) tick();
        n_cmp++; if (if_b.led_grn[0] !== 1'b0) begin
            n_bad++; $display("FAIL win_below_min: got %b want 0", if_b.led_grn[0]);
        end
        repeat (3) begin eops(0, 1); tick(); end
        n_cmp++; if (if_b.led_grn[0] !== 1'b0) begin
            n_bad++; $display("FAIL win_mid_window: got %b want 0", if_b.led_grn[0]);
        end
        tick();
        n_cmp++; if (if_b.led_grn[0] !== 1'b1) begin
            n_bad++; $display("FAIL win_4th_tick: got %b want 1", if_b.led_grn[0]);
        end
        // Third EOP lands in the win_end cycle and must not carry into the next window.
        eops(0, 2); repeat (3) tick();
        eop[0] = 1'b1; ms_en = 1'b1; step(1); eop[0] = 1'b0; ms_en = 1'b0;
        n_cmp++; if (if_b.led_grn[0] !== 1'b0) begin
            n_bad++; $display("FAIL win_coincident: got %b want 0", if_b.led_grn[0]);
        end
        eops(0, 2); repeat (4) tick();
        n_cmp++; if (if_b.led_grn[0] !== 1'b0) begin
            n_bad++; $display("FAIL win_dropped_eop: got %b want 0", if_b.led_grn[0]);
        end
    endtask

    task automatic test_err_latency();
        do_reset();
        eops(1, 1); tick();
        n_cmp++; if (if_a.led_grn !== 4'b0010) begin
            n_bad++; $display("FAIL lat_grn_pre: got %b want 0010", if_a.led_grn);
        end
        err[1] = 1'b1; step(3);
        n_cmp++; if (if_a.led_red !== 4'b0000) begin
            n_bad++; $display("FAIL lat_red_early: got %b want 0000", if_a.led_red);
        end
        step(1);
        n_cmp++; if ({if_a.led_red, if_a.err_any} !== 5'b0010_0) begin
            n_bad++; $display("FAIL lat_red_c4: got %b want 00100", {if_a.led_red, if_a.err_any});
        end
        step(1);
        n_cmp++; if ({if_a.err_any, if_a.led_grn[1]} !== 2'b10) begin
            n_bad++; $display("FAIL lat_c5_any_grn: got %b want 10", {if_a.err_any, if_a.led_grn[1]});
        end
        err[1] = 1'b0; step(3);
        n_cmp++; if (if_a.led_red !== 4'b0010) begin
            n_bad++; $display("FAIL lat_fall_early: got %b want 0010", if_a.led_red);
        end
        step(1);
        n_cmp++; if (if_a.led_red !== 4'b0000) begin
            n_bad++; $display("FAIL lat_fall_c4: got %b want 0000", if_a.led_red);
        end
    endtask

    task automatic test_hold();
        int bad;
        do_reset();
        err[2] = 1'b1; step(10); err[2] = 1'b0; step(6);
        tick(); tick();
        n_cmp++; if (if_c.led_red !== 4'b0100) begin
            n_bad++; $display("FAIL hold_after_2: got %b want 0100", if_c.led_red);
        end
        tick();
        n_cmp++; if ({if_c.led_red, if_c.err_any} !== 5'b0000_1) begin
            n_bad++; $display("FAIL hold_after_3: got %b want 00001", {if_c.led_red, if_c.err_any});
        end
        step(1);
        n_cmp++; if (if_c.err_any !== 1'b0) begin
            n_bad++; $display("FAIL hold_any_fall: got %b want 0", if_c.err_any);
        end
        err[2] = 1'b1; step(10); err[2] = 1'b0; step(6); tick();
        err[2] = 1'b1; bad = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (if_c.led_red[2] !== 1'b1) bad++;
        end
        n_cmp++; if (bad !== 0) begin
            n_bad++; $display("FAIL hold_retrig_gap: got %0d low cycles want 0", bad);
        end
        err[2] = 1'b0; step(6); tick(); tick();
        n_cmp++; if (if_c.led_red[2] !== 1'b1) begin
            n_bad++; $display("FAIL hold_restart: got %b want 1", if_c.led_red[2]);
        end
        tick();
        n_cmp++; if (if_c.led_red[2] !== 1'b0) begin
            n_bad++; $display("FAIL hold_restart_end: got %b want 0", if_c.led_red[2]);
        end
    endtask

    task automatic test_override();
        do_reset();
        err = 4'hF; step(5);
        n_cmp++; if (if_a.led_red !== 4'hF) begin
            n_bad++; $display("FAIL ovr_errs_on: got %h want f", if_a.led_red);
        end
        cfg = 1'b1; lamp = 1'b1; step(1);
        n_cmp++; if ({if_a.led_grn, if_a.led_red} !== 8'h00) begin
            n_bad++; $display("FAIL ovr_cfg_off: got %h want 00", {if_a.led_grn, if_a.led_red});
        end
        step(1);
        n_cmp++; if (if_a.err_any !== 1'b0) begin
            n_bad++; $display("FAIL ovr_cfg_any: got %b want 0", if_a.err_any);
        end
        cfg = 1'b0; step(1);
        n_cmp++; if ({if_a.led_grn, if_a.led_red} !== 8'hFF) begin
            n_bad++; $display("FAIL ovr_lamp_on: got %h want ff", {if_a.led_grn, if_a.led_red});
        end
        lamp = 1'b0; step(1);
        n_cmp++; if ({if_a.led_grn, if_a.led_red} !== 8'h0F) begin
            n_bad++; $display("FAIL ovr_lamp_rel: got %h want 0f", {if_a.led_grn, if_a.led_red});
        end
        err = 4'h0;
    endtask

    task automatic test_sat_and_reset();
        do_reset();
        eops(3, 32); tick();
        n_cmp++; if (if_a.led_grn !== 4'b1000) begin
            n_bad++; $display("FAIL sat_32: got %b want 1000", if_a.led_grn);
        end
        eops(3, 40); tick();
        n_cmp++; if (if_a.led_grn !== 4'b0000) begin
            n_bad++; $display("FAIL sat_40: got %b want 0000", if_a.led_grn);
        end
        err[0] = 1'b1; step(10); err[0] = 1'b0; step(6); tick();
        n_cmp++; if (if_c.led_red !== 4'b0001) begin
            n_bad++; $display("FAIL rst_pre_hold: got %b want 0001", if_c.led_red);
        end
        #2 rst_sys_n = 1'b0;
        #1;
        n_cmp++; if ({if_c.led_red, if_c.err_any, if_a.led_grn, if_a.led_red} !== 13'h0) begin
            n_bad++; $display("FAIL rst_async: got %h want 0",
                              {if_c.led_red, if_c.err_any, if_a.led_grn, if_a.led_red});
        end
        step(1); rst_sys_n = 1'b1; step(1);
        repeat (3) tick();
        n_cmp++; if ({if_c.led_red, if_c.err_any} !== 5'h0) begin
            n_bad++; $display("FAIL rst_no_partial: got %b want 00000", {if_c.led_red, if_c.err_any});
        end
    endtask

    initial begin
        rst_sys_n = 1'b0;
        ms_en = 0; cfg = 0; lamp = 0; slot = 4'hF; eop = 0; err = 0;
        test_reset();
        test_activity();
        test_window();
        test_err_latency();
        test_hold();
        test_override();
        test_sat_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
